// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial CLA adder sequencer.
//   state_t  : FSM encoding (IDLE, RUN, DONE)
//   NIB_W    : width of one CLA slice
//   ID_REQ0/ID_REQ1 : requester id values carried on rsp_id
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int NIB_W = 4;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/cla_add16_sequencer_cla.sv
// 4-bit carry look-ahead adder slice.
//   A, B : 4-bit operands
//   Cin  : carry into bit 0
//   S    : 4-bit sum
//   Cout : carry out of bit 3
module CarryLookAheadAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is formed directly from g/p and Cin, no ripple between bits.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/cla_add16_sequencer.sv
// Multi-cycle W-bit adder: two requesters, round-robin arbitration, one
// nibble per cycle through a single 4-bit CLA slice, carry held in carry_reg.
//   clk, rst_n              : clock, asynchronous active-low reset
//   reqN_valid/reqN_ready   : job handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_cin: job operands and carry-in
//   rsp_valid/rsp_ready     : result handshake
//   rsp_sum, rsp_cout       : (a + b + cin) mod 2^W and bit W of the sum
//   rsp_id                  : requester that issued the job
//   dbg_state               : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. reqN_ready depends combinationally on the valids while IDLE and
// is 0 otherwise. rsp_valid, once raised, stays high with rsp_sum/rsp_cout/
// rsp_id stable until the edge where rsp_ready is also high.
module cla_add16_sequencer
  import cla_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIB_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output state_t       dbg_state
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t           state;
  logic             prio;
  logic [IW-1:0]    nib_idx;
  logic             carry_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             id_reg;
  logic             valid_reg;
  logic             cout_reg;

  logic             gnt0;
  logic             gnt1;
  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_cout;

  // Arbiter: a lone requester always wins; on contention prio picks.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || prio == ID_REQ0)) gnt0 = 1'b1;
      else if (req1_valid)                                  gnt1 = 1'b1;
    end
  end

  // Select the current nibble of each operand.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (nib_idx == IW'(i)) begin
        nib_a = a_reg[i*NIB_W +: NIB_W];
        nib_b = b_reg[i*NIB_W +: NIB_W];
      end
    end
  end

  CarryLookAheadAdder u_cla (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_reg),
    .S    (nib_s),
    .Cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= ID_REQ0;
      nib_idx   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      id_reg    <= ID_REQ0;
      valid_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            a_reg     <= gnt1 ? req1_a   : req0_a;
            b_reg     <= gnt1 ? req1_b   : req0_b;
            carry_reg <= gnt1 ? req1_cin : req0_cin;
            id_reg    <= gnt1 ? ID_REQ1  : ID_REQ0;
            prio      <= gnt1 ? ID_REQ0  : ID_REQ1;
            nib_idx   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (nib_idx == IW'(i)) sum_reg[i*NIB_W +: NIB_W] <= nib_s;
          end
          carry_reg <= nib_cout;
          if (nib_idx == IW'(NIBBLES - 1)) begin
            nib_idx   <= '0;
            valid_reg <= 1'b1;
            cout_reg  <= nib_cout;
            state     <= DONE;
          end else begin
            nib_idx <= nib_idx + IW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            valid_reg <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = valid_reg;
  assign rsp_sum    = sum_reg;
  assign rsp_cout   = cout_reg;
  assign rsp_id     = id_reg;
  assign dbg_state  = state;

endmodule

// File: tb/tb_cla_add16_sequencer.sv
// Self-checking bench for cla_add16_sequencer: transaction-level reference
// model (arbitration + a + b + cin) compared every cycle, plus literal
// expectations for the directed cases.
module tb_cla_add16_sequencer;
  import cla_seq_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int EW      = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic         req0_cin = 1'b0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         req1_cin = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;
  state_t       dbg_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  cla_add16_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic note_timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: bounded wait expired at %0t", name, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  // phase: 0 waiting for a grant, 1 computing, 2 result offered.
  logic [EW-1:0] exp_q[$];
  int            m_phase = 0;
  int            m_count = 0;
  logic          m_prio  = 1'b0;
  logic          m_gid;
  logic [W:0]    m_total;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_count = 0;
      m_prio  = 1'b0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (req0_valid || req1_valid) begin
          m_gid = (req0_valid && req1_valid) ? m_prio : req1_valid;
          if (m_gid) m_total = {1'b0, req1_a} + {1'b0, req1_b} + (W+1)'(req1_cin);
          else       m_total = {1'b0, req0_a} + {1'b0, req0_b} + (W+1)'(req0_cin);
          exp_q.push_back({m_gid, m_total});
          m_prio  = ~m_gid;
          m_phase = 1;
          m_count = NIBBLES;
        end
        1: begin
          m_count--;
          if (m_count == 0) m_phase = 2;
        end
        default: if (rsp_ready) begin
          void'(exp_q.pop_front());
          m_phase = 0;
        end
      endcase
    end
  end

  // Compare process: every falling edge.
  logic          exp_r0;
  logic          exp_r1;
  logic [EW-1:0] exp_e;

  always @(negedge clk) begin
    exp_r0 = (m_phase == 0) && req0_valid && (!req1_valid || !m_prio);
    exp_r1 = (m_phase == 0) && req1_valid && (!req0_valid || m_prio);
    check("req0_ready", 32'(req0_ready), 32'(exp_r0));
    check("req1_ready", 32'(req1_ready), 32'(exp_r1));
    check("ready_exclusive", 32'(req0_ready && req1_ready), 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    if (m_phase == 2 && exp_q.size() > 0) begin
      exp_e = exp_q[0];
      check("rsp_sum",  32'(rsp_sum),  32'(exp_e[W-1:0]));
      check("rsp_cout", 32'(rsp_cout), 32'(exp_e[W]));
      check("rsp_id",   32'(rsp_id),   32'(exp_e[W+1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_sum"},   32'(rsp_sum),   32'd0);
    check({tag, "_rsp_cout"},  32'(rsp_cout),  32'd0);
    check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // One job from one requester; stall = DONE cycles held off before taking it.
  task automatic do_job(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int stall,
                        output logic [W-1:0] s, output logic co, output logic rid,
                        output int lat);
    logic got;
    clear_inputs();
    if (id) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    s = '0; co = 1'b0; rid = 1'b0; lat = -1;
    if (!got) begin
      note_timeout("accept_wait");
      clear_inputs();
      return;
    end
    tick();
    clear_inputs();
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!rsp_valid) begin
      note_timeout("rsp_wait");
      return;
    end
    // While stalled, offer fresh jobs on both ports; neither may be accepted.
    if (stall > 0) begin
      req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
      req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
    end
    repeat (stall) tick();
    s = rsp_sum; co = rsp_cout; rid = rsp_id;
    rsp_ready = 1'b1;
    tick();
    clear_inputs();
  endtask

  // Keep both requesters valid, take every response, record n of them.
  logic [EW-1:0] col_q[$];

  task automatic run_both(input int n, input logic rnd);
    logic a0;
    logic a1;
    int   budget;
    col_q.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    budget = 0;
    while (col_q.size() < n && budget < 200) begin
      @(negedge clk);
      a0 = req0_ready;
      a1 = req1_ready;
      if (rsp_valid) col_q.push_back({rsp_id, rsp_cout, rsp_sum});
      tick();
      if (rnd && a0) begin req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom); end
      if (rnd && a1) begin req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom); end
      budget++;
    end
    clear_inputs();
    if (col_q.size() < n) note_timeout("run_both");
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] s;
  logic         co;
  logic         rid;
  int           lat;

  initial begin
    // Reset state
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    check("reset_req0_ready", 32'(req0_ready), 32'd0);
    check("reset_req1_ready", 32'(req1_ready), 32'd0);
    do_reset();

    // Single job
    do_job(1'b0, 16'h00FF, 16'h0001, 1'b0, 0, s, co, rid, lat);
    check("single_latency", 32'(lat), 32'd4);
    check("single_sum", 32'(s), 32'h0100);
    check("single_cout", 32'(co), 32'd0);
    check("single_id", 32'(rid), 32'd0);

    // Full carry ripple
    do_job(1'b1, 16'hFFFF, 16'h0000, 1'b1, 0, s, co, rid, lat);
    check("ripple_sum", 32'(s), 32'h0000);
    check("ripple_cout", 32'(co), 32'd1);
    check("ripple_id", 32'(rid), 32'd1);

    // Backpressure: 5 stalled DONE cycles
    do_job(1'b0, 16'h8000, 16'h8000, 1'b1, 5, s, co, rid, lat);
    check("stall_sum", 32'(s), 32'h0001);
    check("stall_cout", 32'(co), 32'd1);
    check("stall_id", 32'(rid), 32'd0);
    repeat (2) tick();

    // Simultaneous requests right after reset
    do_reset();
    req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0;
    req1_a = 16'hABCD; req1_b = 16'h1111; req1_cin = 1'b1;
    run_both(2, 1'b0);
    if (col_q.size() >= 2) begin
      check("simul_first",  32'(col_q[0]), 32'({1'b0, 1'b0, 16'h5555}));
      check("simul_second", 32'(col_q[1]), 32'({1'b1, 1'b0, 16'hBCDF}));
    end
    repeat (2) tick();

    // Reset after two RUN cycles
    do_reset();
    req1_a = 16'h7777; req1_b = 16'h1111; req1_cin = 1'b1; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    do_job(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 0, s, co, rid, lat);
    check("after_reset_sum", 32'(s), 32'h1000);
    check("after_reset_cout", 32'(co), 32'd0);

    // Fairness: both held valid for 4 jobs, random operands
    do_reset();
    req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
    run_both(4, 1'b1);
    for (int i = 0; i < 4 && i < col_q.size(); i++)
      check($sformatf("fair_id%0d", i), 32'(col_q[i][W+1]), 32'(i % 2));
    repeat (2) tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    clear_inputs();
    repeat (10) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
